// File: rtl/npc_pkg.sv
// Shared types for the next-PC redirect unit: op kinds, FSM states, link registers.
// Latency: n/a (types only).  Backpressure: n/a.
package npc_pkg;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_BR,
        OP_JAL,
        OP_JALR
    } op_kind_e;

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } state_e;

    localparam logic [4:0] LINK_X1 = 5'd1;
    localparam logic [4:0] LINK_X5 = 5'd5;

    function automatic logic is_link(input logic [4:0] r);
        return (r == LINK_X1) || (r == LINK_X5);
    endfunction

endpackage

// File: rtl/npc_redirect_unit_if.sv
// Execute-to-redirect and redirect-to-fetch signal bundle; slave is the unit, master its environment.
// Latency: n/a (wiring only).  Backpressure: in_ready / redir_ready carried here.
interface npc_redirect_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] alu_result;
    logic            branch_en;
    logic            jal_en;
    logic            jalr_en;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic            flush;
    logic            redir_valid;
    logic            redir_ready;
    logic [XLEN-1:0] redir_pc;
    logic [XLEN-1:0] link_pc;
    logic            misalign;
    logic            ras_mispredict;

    modport master (
        output in_valid, pc, imm, alu_result, branch_en, jal_en, jalr_en, rd, rs1, flush, redir_ready,
        input  in_ready, redir_valid, redir_pc, link_pc, misalign, ras_mispredict
    );

    modport slave (
        input  in_valid, pc, imm, alu_result, branch_en, jal_en, jalr_en, rd, rs1, flush, redir_ready,
        output in_ready, redir_valid, redir_pc, link_pc, misalign, ras_mispredict
    );
endinterface

// File: rtl/npc_ras.sv
// Circular return-address stack; overflow overwrites the oldest entry, pop on empty is ignored.
// Latency: top_dat combinational from state, push/pop take effect next cycle.  Backpressure: none.
module npc_ras #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push_vld,
    input  logic            pop_vld,
    input  logic [XLEN-1:0] push_dat,
    output logic            top_vld,
    output logic [XLEN-1:0] top_dat
);
    localparam int PW = $clog2(DEPTH);

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   top_ptr;
    logic [PW:0]     count_q;
    logic            do_pop;

    assign top_ptr = wr_ptr_q - PW'(1);
    assign top_vld = (count_q != '0);
    assign top_dat = mem_q[top_ptr];
    assign do_pop  = pop_vld && top_vld;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (do_pop && !push_vld) begin
            wr_ptr_q <= top_ptr;
            count_q  <= count_q - (PW+1)'(1);
        end else if (push_vld && !do_pop) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
            if (count_q != (PW+1)'(DEPTH))
                count_q <= count_q + (PW+1)'(1);
        end
    end

    // Pop-then-push replaces the top entry in place; pointers stay put.
    always_ff @(posedge clk) begin
        if (push_vld) begin
            if (do_pop)
                mem_q[top_ptr] <= push_dat;
            else
                mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/npc_redirect_unit.sv
// Next-PC calculator: target, link and misalign for branch/jal/jalr, held as a registered redirect.
// Latency 1 cycle; result held until redir_ready, in_ready = !flush && (!redir_valid || redir_ready).
// Optional return-address stack compiled in with MSPU_NPC_RAS_EN.
module npc_redirect_unit
    import npc_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int INSN_BYTES = 4,
    parameter int RAS_DEPTH  = 4
) (
    input  logic                clk,
    input  logic                reset,
    npc_redirect_unit_if.slave  bus
);
    localparam logic [XLEN-1:0] STEP       = XLEN'(INSN_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSN_BYTES - 1);

    typedef struct packed {
        logic [XLEN-1:0] redir_pc;
        logic [XLEN-1:0] link_pc;
        logic            misalign;
        logic            ras_mispredict;
    } res_t;

    op_kind_e        op_kind;
    state_e          state_q, state_d;
    res_t            res_q, res_d;
    logic            redir_valid;
    logic            in_ready;
    logic            accept;
    logic            jump_like;
    logic [XLEN-1:0] link_next;
    logic [XLEN-1:0] target;
    logic            ras_mis_d;

    always_comb begin
        op_kind = OP_NONE;
        if (bus.branch_en)
            op_kind = OP_BR;
        else if (bus.jal_en)
            op_kind = OP_JAL;
        else if (bus.jalr_en)
            op_kind = OP_JALR;
    end

    assign link_next = bus.pc + STEP;

    always_comb begin
        target    = link_next;
        jump_like = 1'b0;
        case (op_kind)
            OP_BR: begin
                if (bus.alu_result[0]) begin
                    target    = bus.pc + bus.imm;
                    jump_like = 1'b1;
                end
            end
            OP_JAL: begin
                target    = bus.pc + bus.imm;
                jump_like = 1'b1;
            end
            OP_JALR: begin
                target    = {bus.alu_result[XLEN-1:1], 1'b0};
                jump_like = 1'b1;
            end
            default: ;
        endcase
    end

    assign in_ready = !bus.flush && (!redir_valid || bus.redir_ready);
    assign accept   = bus.in_valid && in_ready && (op_kind != OP_NONE);

`ifdef MSPU_NPC_RAS_EN
    logic            rd_link, rs1_link;
    logic            ras_push, ras_pop;
    logic            ras_top_vld;
    logic [XLEN-1:0] ras_top_dat;

    assign rd_link  = is_link(bus.rd);
    assign rs1_link = is_link(bus.rs1);
    assign ras_push = accept && ((op_kind == OP_JAL) || (op_kind == OP_JALR)) && rd_link;
    // jalr x1,x1 / x5,x5 is a plain call: push only, no pop.
    assign ras_pop  = accept && (op_kind == OP_JALR) && rs1_link && (!rd_link || (bus.rd != bus.rs1));

    npc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .reset    (reset),
        .push_vld (ras_push),
        .pop_vld  (ras_pop),
        .push_dat (link_next),
        .top_vld  (ras_top_vld),
        .top_dat  (ras_top_dat)
    );

    assign ras_mis_d = ras_pop && ras_top_vld && (ras_top_dat != target);
`else
    logic unused_ras;
    assign unused_ras = ^{bus.rd, bus.rs1};
    assign ras_mis_d  = 1'b0;
`endif

    always_comb begin
        res_d.redir_pc       = target;
        res_d.link_pc        = link_next;
        res_d.misalign       = jump_like && ((target & ALIGN_MASK) != '0);
        res_d.ras_mispredict = ras_mis_d;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (accept) state_d = S_HOLD;
                S_HOLD:  if (bus.redir_ready && !accept) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        redir_valid = (state_q == S_HOLD);
    end

    // Payload only loads on accept, so it stays stable while fetch stalls.
    always_ff @(posedge clk) begin
        if (reset)
            res_q <= '0;
        else if (accept)
            res_q <= res_d;
    end

    assign bus.in_ready       = in_ready;
    assign bus.redir_valid    = redir_valid;
    assign bus.redir_pc       = res_q.redir_pc;
    assign bus.link_pc        = res_q.link_pc;
    assign bus.misalign       = res_q.misalign;
    assign bus.ras_mispredict = res_q.ras_mispredict;

endmodule

// File: doc/npc_redirect_unit.md
Name: npc_redirect_unit

Overview:
- Next-generation next-PC calculator for the mspu core.
- Takes one resolved control-transfer op per handshake from execute and computes the target PC and the link value (pc+4).
- Detects misaligned targets.
- Presents the result to fetch as a registered redirect, held under a valid/ready handshake.
- Sits between the ALU/branch compare stage and the fetch PC mux; replaces the purely combinational next-PC path.

Parameters:
- XLEN, 32, data/address width of pc, imm, alu_result and all PC outputs.
- INSN_BYTES, 4, sequential PC increment; also the alignment granule (must be a power of two, 2 or 4).
- RAS_DEPTH, 4, entries in the return-address stack; used only when the optional feature is compiled in; must be a power of two, ≥2.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  execute presents an op this cycle.
- in_ready  out  1  unit accepts the op this cycle.
- pc  in  XLEN  PC of the op.
- imm  in  XLEN  sign-extended immediate.
- alu_result  in  XLEN  bit0 = branch taken for branches; full value = rs1+imm for jalr.
- branch_en  in  1  op is a conditional branch.
- jal_en  in  1  op is jal.
- jalr_en  in  1  op is jalr.
- rd  in  5  destination register index (RAS only).
- rs1  in  5  source register index (RAS only).
- flush  in  1  discard any held redirect.
- redir_valid  out  1  redirect to fetch pending.
- redir_ready  in  1  fetch consumes the redirect.
- redir_pc  out  XLEN  target PC.
- link_pc  out  XLEN  pc+INSN_BYTES of the accepted op, for rd writeback.
- misalign  out  1  held result is a misaligned-target exception, not a redirect.
- ras_mispredict  out  1  jalr target differed from RAS top (RAS only; 0 otherwise).

Behaviour:
- Accept condition: in_valid && in_ready && (branch_en|jal_en|jalr_en).
  - in_valid with no enable set is accepted and produces nothing.
  - More than one enable set: priority branch > jal > jalr.
- Target computation, modulo 2^XLEN:
  - branch, taken (alu_result[0]=1): pc+imm.
  - branch, not taken: pc+INSN_BYTES.
  - jal: pc+imm.
  - jalr: alu_result with bit0 cleared.
- link_pc = pc+INSN_BYTES for every accepted op.
- Misalignment: target mod INSN_BYTES != 0 → misalign=1 and redir_pc = the faulting target. Not-taken branches never fault.
- Output FSM:
  - IDLE → HOLD on accept.
  - HOLD → IDLE on redir_ready && !accept.
  - HOLD → HOLD with new data on redir_ready && accept (back-to-back, no bubble).
  - Latency is 1 cycle: registered outputs are valid the cycle after accept.
- Handshake:
  - in_ready = !redir_valid || redir_ready (combinational from redir_ready).
  - redir_pc, link_pc and misalign are stable while redir_valid && !redir_ready.
- flush:
  - Forces IDLE next cycle and clears redir_valid.
  - in_ready=0 while flush=1; flush wins over simultaneous accept.
- Reset: state IDLE; redir_valid, misalign and ras_mispredict are 0; redir_pc and link_pc are 0; in_ready=1 after reset. Reset mid-HOLD drops the held redirect.
- Wrap-around: pc+imm and pc+4 overflow silently; no flag.

Optional Feature:
- Macro: MSPU_NPC_RAS_EN.
- With the macro, a RAS_DEPTH return-address stack with circular pointer and occupancy count:
  - Push link_pc on accepted jal/jalr with rd ∈ {1,5}.
  - Pop on accepted jalr with rs1 ∈ {1,5} and rd ∉ {1,5}.
  - Push+pop (rd and rs1 both link, rd≠rs1): pop then push.
  - Overflow overwrites the oldest entry; count saturates at RAS_DEPTH.
  - Pop on empty: no pointer change, no compare.
  - On pop, ras_mispredict=1 (registered with redir_valid) if the popped entry ≠ computed target.
  - flush does not alter the RAS; reset empties it.
- Without the macro: no stack storage; rd and rs1 are ignored; ras_mispredict is tied to 0.

Decomposition:
- Package npc_pkg:
  - typedef op kind enum {OP_NONE, OP_BR, OP_JAL, OP_JALR}.
  - FSM state enum {S_IDLE, S_HOLD}.
  - Link-register constants LINK_X1=1, LINK_X5=5.
- Sub-module npc_ras, instantiated only under MSPU_NPC_RAS_EN: push/pop/data interface, circular buffer.

Test Plan:
- Reset, then branch pc=0x100, imm=0x20, alu_result=1, redir_ready=1 → next cycle redir_valid=1, redir_pc=0x120, link_pc=0x104, misalign=0. Same op with alu_result=0 → redir_pc=0x104.
- jalr alu_result=0x2001, redir_ready=0 for 3 cycles → redir_pc=0x2000 held stable, in_ready=0 throughout; ready=1 → consumed, then IDLE.
- jal pc=0x10, imm=0x6 → redir_pc=0x16, misalign=1. Back-to-back ops with redir_ready=1 each cycle → one redirect per cycle, no bubble.
- flush asserted in HOLD together with in_valid → redir_valid=0 next cycle, op not accepted. Reset asserted mid-HOLD → all outputs 0.
- Wrap: pc=0xFFFFFFFC, jal imm=8 → redir_pc=0x4.
- MSPU_NPC_RAS_EN: jal rd=1 at pc=0x40; then jalr rs1=1, rd=0, alu_result=0x44 → ras_mispredict=0. Repeat with alu_result=0x48 → ras_mispredict=1. Five pushes with RAS_DEPTH=4 → oldest lost, four pops return newest-first.
